// File: rtl/pusch_dr_pkg.sv
// rtl/pusch_dr_pkg.sv - shared constants and RBG sideband type for the PUSCH beam power path
package pusch_dr_pkg;

  localparam int BEAM   = 16;
  localparam int TW     = 16;
  localparam int PW     = 40;
  localparam int STAGES = 4;
  localparam int RBG_W  = 8;

  typedef struct packed {
    logic             vld;
    logic             sop;
    logic             eop;
    logic             load;
    logic             symb_1st;
    logic [RBG_W-1:0] rbg_num;
  } rbg_sb_t;

  function automatic logic [RBG_W-1:0] sat_inc(input logic [RBG_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/beam_pwr_lane.sv
// rtl/beam_pwr_lane.sv - one beam: shift/saturate, square, I2+Q2, saturating RBG accumulator
module beam_pwr_lane #(
  parameter int OW    = 48,
  parameter int SHIFT = 16,
  parameter int TW    = pusch_dr_pkg::TW,
  parameter int PW    = pusch_dr_pkg::PW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic [OW-1:0] i_data_i,
  input  logic [OW-1:0] i_data_q,
  input  logic          i_s3_vld,
  input  logic          i_s3_sop,
  input  logic          i_s3_close,
  output logic [PW-1:0] o_pwr,
  output logic          o_sat
);
  import pusch_dr_pkg::*;

  // Returns {saturated, value}; value fits when all bits above the TW-1 sign bit agree.
  function automatic logic [TW:0] shift_sat(input logic [OW-1:0] d);
    logic signed [OW-1:0] sh;
    sh = $signed(d) >>> SHIFT;
    if ((&sh[OW-1:TW-1]) || !(|sh[OW-1:TW-1]))
      return {1'b0, sh[TW-1:0]};
    return {1'b1, sh[OW-1], {(TW-1){~sh[OW-1]}}};
  endfunction

  logic [TW:0]            i_ss, q_ss;
  logic signed [TW-1:0]   s1_i, s1_q;
  logic                   s1_sat;
  logic signed [2*TW-1:0] i_ext, q_ext;
  logic [2*TW-1:0]        ii_m, qq_m;
  logic [2*TW-1:0]        s2_ii, s2_qq;
  logic                   s2_sat;
  logic [2*TW:0]          s3_pwr;
  logic                   s3_sat;
  logic [PW-1:0]          acc, acc_base, acc_nxt;
  logic [PW:0]            acc_sum;
  logic                   acc_sat, sat_nxt;

  assign i_ss  = shift_sat(i_data_i);
  assign q_ss  = shift_sat(i_data_q);
  assign i_ext = {{TW{s1_i[TW-1]}}, s1_i};
  assign q_ext = {{TW{s1_q[TW-1]}}, s1_q};
  assign ii_m  = i_ext * i_ext;
  assign qq_m  = q_ext * q_ext;

  // An sop RE restarts the sum, dropping any partial RBG that was never closed.
  always_comb begin
    acc_base = i_s3_sop ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {{(PW-2*TW){1'b0}}, s3_pwr};
    acc_nxt  = acc_sum[PW] ? '1 : acc_sum[PW-1:0];
    sat_nxt  = (acc_sat & ~i_s3_sop) | acc_sum[PW] | s3_sat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_i    <= '0;
      s1_q    <= '0;
      s1_sat  <= 1'b0;
      s2_ii   <= '0;
      s2_qq   <= '0;
      s2_sat  <= 1'b0;
      s3_pwr  <= '0;
      s3_sat  <= 1'b0;
      acc     <= '0;
      acc_sat <= 1'b0;
      o_pwr   <= '0;
      o_sat   <= 1'b0;
    end else begin
      s1_i   <= i_ss[TW-1:0];
      s1_q   <= q_ss[TW-1:0];
      s1_sat <= i_ss[TW] | q_ss[TW];
      s2_ii  <= ii_m;
      s2_qq  <= qq_m;
      s2_sat <= s1_sat;
      s3_pwr <= {1'b0, s2_ii} + {1'b0, s2_qq};
      s3_sat <= s2_sat;
      if (i_clr) begin
        acc     <= '0;
        acc_sat <= 1'b0;
      end else if (i_s3_vld) begin
        if (i_s3_close) begin
          o_pwr   <= acc_nxt;
          o_sat   <= sat_nxt;
          acc     <= '0;
          acc_sat <= 1'b0;
        end else begin
          acc     <= acc_nxt;
          acc_sat <= sat_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/beam_pwr_acc.sv
// rtl/beam_pwr_acc.sv - per-beam RBG power accumulation with shared sideband pipeline and RE counter
module beam_pwr_acc #(
  parameter int BEAM  = pusch_dr_pkg::BEAM,
  parameter int OW    = 48,
  parameter int SHIFT = 16,
  parameter int TW    = pusch_dr_pkg::TW,
  parameter int PW    = pusch_dr_pkg::PW
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BEAM*OW-1:0] i_data_i,
  input  logic [BEAM*OW-1:0] i_data_q,
  input  logic               i_tvalid,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic [7:0]         i_rbg_num,
  input  logic               i_rbg_load,
  input  logic               i_symb_clr,
  input  logic               i_symb_1st,
  output logic [BEAM*PW-1:0] o_pwr,
  output logic               o_pwr_vld,
  output logic [7:0]         o_rbg_num,
  output logic [7:0]         o_re_cnt,
  output logic               o_symb_1st,
  output logic               o_eop,
  output logic [BEAM-1:0]    o_sat
);
  import pusch_dr_pkg::*;

  rbg_sb_t          sb_in;
  rbg_sb_t          sb_pipe [STAGES-1];
  rbg_sb_t          s3;
  logic             s3_close;
  logic [RBG_W-1:0] re_cnt, cnt_nxt;

  // Control flags only mean something on valid REs, so bubbles enter the pipe as all-zero.
  always_comb begin
    sb_in     = '0;
    sb_in.vld = i_tvalid;
    if (i_tvalid) begin
      sb_in.sop      = i_sop;
      sb_in.eop      = i_eop;
      sb_in.load     = i_rbg_load;
      sb_in.symb_1st = i_symb_1st;
      sb_in.rbg_num  = i_rbg_num;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_symb_clr) begin
      for (int k = 0; k < STAGES-1; k++) sb_pipe[k] <= '0;
    end else begin
      sb_pipe[0] <= sb_in;
      for (int k = 1; k < STAGES-1; k++) sb_pipe[k] <= sb_pipe[k-1];
    end
  end

  assign s3       = sb_pipe[STAGES-2];
  assign s3_close = s3.load | s3.eop;
  assign cnt_nxt  = sat_inc(s3.sop ? '0 : re_cnt);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      re_cnt     <= '0;
      o_pwr_vld  <= 1'b0;
      o_rbg_num  <= '0;
      o_re_cnt   <= '0;
      o_symb_1st <= 1'b0;
      o_eop      <= 1'b0;
    end else begin
      o_pwr_vld <= 1'b0;
      if (i_symb_clr) begin
        re_cnt <= '0;
      end else if (s3.vld) begin
        if (s3_close) begin
          o_pwr_vld  <= 1'b1;
          o_re_cnt   <= cnt_nxt;
          o_rbg_num  <= s3.rbg_num;
          o_symb_1st <= s3.symb_1st;
          o_eop      <= s3.eop;
          re_cnt     <= '0;
        end else begin
          re_cnt <= cnt_nxt;
        end
      end
    end
  end

  for (genvar b = 0; b < BEAM; b++) begin : g_lane
    beam_pwr_lane #(
      .OW   (OW),
      .SHIFT(SHIFT),
      .TW   (TW),
      .PW   (PW)
    ) u_lane (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (i_symb_clr),
      .i_data_i  (i_data_i[b*OW +: OW]),
      .i_data_q  (i_data_q[b*OW +: OW]),
      .i_s3_vld  (s3.vld),
      .i_s3_sop  (s3.sop),
      .i_s3_close(s3_close),
      .o_pwr     (o_pwr[b*PW +: PW]),
      .o_sat     (o_sat[b])
    );
  end

endmodule

// File: tb/tb_beam_pwr_acc.sv
// tb/tb_beam_pwr_acc.sv - directed table-driven bench for beam_pwr_acc
module tb_beam_pwr_acc;
  localparam int BEAM = 16;
  localparam int OW   = 48;
  localparam int PW   = 40;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic [BEAM*OW-1:0] i_data_i, i_data_q;
  logic               i_tvalid, i_sop, i_eop, i_rbg_load, i_symb_clr, i_symb_1st;
  logic [7:0]         i_rbg_num;
  logic [BEAM*PW-1:0] o_pwr;
  logic               o_pwr_vld, o_symb_1st, o_eop;
  logic [7:0]         o_rbg_num, o_re_cnt;
  logic [BEAM-1:0]    o_sat;

  beam_pwr_acc dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_data_i  (i_data_i),
    .i_data_q  (i_data_q),
    .i_tvalid  (i_tvalid),
    .i_sop     (i_sop),
    .i_eop     (i_eop),
    .i_rbg_num (i_rbg_num),
    .i_rbg_load(i_rbg_load),
    .i_symb_clr(i_symb_clr),
    .i_symb_1st(i_symb_1st),
    .o_pwr     (o_pwr),
    .o_pwr_vld (o_pwr_vld),
    .o_rbg_num (o_rbg_num),
    .o_re_cnt  (o_re_cnt),
    .o_symb_1st(o_symb_1st),
    .o_eop     (o_eop),
    .o_sat     (o_sat)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int                 pulse_cnt = 0;
  int                 cap_cyc = 0;
  logic [BEAM*PW-1:0] cap_pwr = '0;
  logic [7:0]         cap_cnt = '0, cap_rbg = '0;
  logic               cap_eop = 1'b0, cap_s1st = 1'b0;
  logic [BEAM-1:0]    cap_sat = '0;

  always @(negedge i_clk) begin
    if (o_pwr_vld) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_cyc   <= cyc;
      cap_pwr   <= o_pwr;
      cap_cnt   <= o_re_cnt;
      cap_rbg   <= o_rbg_num;
      cap_eop   <= o_eop;
      cap_s1st  <= o_symb_1st;
      cap_sat   <= o_sat;
    end
  end

  int n_err = 0;
  int n_chk = 0;
  int last_cyc = 0;

  typedef struct {
    int            n_re;
    int            bubbles;
    logic [OW-1:0] iv;
    logic [OW-1:0] qv;
    bit            use_eop;
    logic [PW-1:0] exp_pwr;
    int            exp_cnt;
    bit            exp_sat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_rbg(input int n, input int bub, input logic [OW-1:0] iv, input logic [OW-1:0] qv,
                          input bit use_eop, input bit close, input bit sop1,
                          input logic [7:0] rbg, input logic s1st);
    for (int r = 1; r <= n; r++) begin
      i_data_i   = {BEAM{iv}};
      i_data_q   = {BEAM{qv}};
      i_tvalid   = 1'b1;
      i_sop      = sop1 && (r == 1);
      i_eop      = close && use_eop && (r == n);
      i_rbg_load = close && !use_eop && (r == n);
      i_rbg_num  = rbg;
      i_symb_1st = s1st;
      @(posedge i_clk);
      last_cyc = cyc;
      #1;
      if (r == 2) begin
        for (int b = 0; b < bub; b++) begin
          i_tvalid   = 1'b0;
          i_sop      = 1'b1;
          i_eop      = 1'b1;
          i_rbg_load = 1'b1;
          i_data_i   = {BEAM{48'h7FFF_FFFF_0000}};
          @(posedge i_clk);
          #1;
        end
      end
    end
    i_tvalid   = 1'b0;
    i_sop      = 1'b0;
    i_eop      = 1'b0;
    i_rbg_load = 1'b0;
  endtask

  task automatic expect_close(input string tag, input int pc0, input logic [PW-1:0] ep, input int ecnt,
                              input bit eeop, input bit esat, input logic [7:0] erbg, input logic es1);
    int w;
    w = 0;
    while (pulse_cnt == pc0 && w < 20) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    chk({tag, "_pulse"}, 64'(pulse_cnt - pc0), 1);
    chk({tag, "_latency"}, 64'(cap_cyc - last_cyc), 4);
    for (int b = 0; b < BEAM; b++)
      chk($sformatf("%s_pwr_b%0d", tag, b), 64'(cap_pwr[b*PW +: PW]), 64'(ep));
    chk({tag, "_re_cnt"}, 64'(cap_cnt), 64'(ecnt));
    chk({tag, "_eop"}, 64'(cap_eop), 64'(eeop));
    chk({tag, "_sat"}, 64'(cap_sat), 64'({BEAM{esat}}));
    chk({tag, "_rbg_num"}, 64'(cap_rbg), 64'(erbg));
    chk({tag, "_symb_1st"}, 64'(cap_s1st), 64'(es1));
    repeat (3) @(negedge i_clk);
    #1;
    chk({tag, "_one_pulse"}, 64'(pulse_cnt - pc0), 1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pwr"}, 64'(|o_pwr), 0);
    chk({tag, "_vld"}, 64'(o_pwr_vld), 0);
    chk({tag, "_rbg_num"}, 64'(o_rbg_num), 0);
    chk({tag, "_re_cnt"}, 64'(o_re_cnt), 0);
    chk({tag, "_symb_1st"}, 64'(o_symb_1st), 0);
    chk({tag, "_eop"}, 64'(o_eop), 0);
    chk({tag, "_sat"}, 64'(o_sat), 0);
  endtask

  localparam logic [OW-1:0] ONE = 48'h0000_0001_0000;

  initial begin
    int pc0;
    i_reset    = 1'b1;
    i_data_i   = '0;
    i_data_q   = '0;
    i_tvalid   = 1'b0;
    i_sop      = 1'b0;
    i_eop      = 1'b0;
    i_rbg_load = 1'b0;
    i_symb_clr = 1'b0;
    i_symb_1st = 1'b0;
    i_rbg_num  = '0;
    #1;
    repeat (3) @(posedge i_clk);
    #1;
    chk_outputs_zero("reset");
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    vecs[0] = '{12,  0, ONE, ONE, 1'b0, 40'd24, 12, 1'b0};
    vecs[1] = '{12,  3, ONE, ONE, 1'b0, 40'd24, 12, 1'b0};
    vecs[2] = '{3,   0, 48'h7FFF_FFFF_0000, 48'h0, 1'b0, 40'd3221028867, 3, 1'b1};
    vecs[3] = '{5,   0, ONE, ONE, 1'b1, 40'd10, 5, 1'b0};
    vecs[4] = '{4,   0, 48'hFFFF_FFFE_0000, 48'h0000_0003_0000, 1'b0, 40'd52, 4, 1'b0};
    vecs[5] = '{2,   0, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 40'd4294967296, 2, 1'b1};
    vecs[6] = '{513, 0, 48'h0000_7FFF_0000, 48'h0000_7FFF_0000, 1'b0, 40'hFF_FFFF_FFFF, 255, 1'b1};

    for (int v = 0; v < 7; v++) begin
      pc0 = pulse_cnt;
      send_rbg(vecs[v].n_re, vecs[v].bubbles, vecs[v].iv, vecs[v].qv, vecs[v].use_eop,
               1'b1, 1'b0, 8'(10 + v), 1'(v % 2));
      expect_close($sformatf("vec%0d", v), pc0, vecs[v].exp_pwr, vecs[v].exp_cnt,
                   vecs[v].use_eop, vecs[v].exp_sat, 8'(10 + v), 1'(v % 2));
    end

    // Clear hitting the closing RE while it sits in S1, S2 and S3.
    for (int d = 1; d <= 3; d++) begin
      pc0 = pulse_cnt;
      send_rbg(12, 0, ONE, ONE, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0);
      repeat (d - 1) begin
        @(posedge i_clk);
        #1;
      end
      i_symb_clr = 1'b1;
      @(posedge i_clk);
      #1;
      i_symb_clr = 1'b0;
      repeat (10) @(posedge i_clk);
      #1;
      chk($sformatf("clr_d%0d_no_pulse", d), 64'(pulse_cnt - pc0), 0);
    end
    pc0 = pulse_cnt;
    send_rbg(12, 0, ONE, ONE, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1);
    expect_close("after_clr", pc0, 40'd24, 12, 1'b0, 1'b0, 8'h41, 1'b1);

    // Reset in the middle of an RBG.
    pc0 = pulse_cnt;
    send_rbg(6, 0, ONE, ONE, 1'b0, 1'b0, 1'b0, 8'h50, 1'b0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk_outputs_zero("mid_reset");
    repeat (2) @(posedge i_clk);
    #1;
    chk_outputs_zero("mid_reset_hold");
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    chk("mid_reset_no_pulse", 64'(pulse_cnt - pc0), 0);
    pc0 = pulse_cnt;
    send_rbg(12, 0, ONE, ONE, 1'b0, 1'b1, 1'b0, 8'h51, 1'b0);
    expect_close("after_reset", pc0, 40'd24, 12, 1'b0, 1'b0, 8'h51, 1'b0);

    // Open RBG abandoned by a new sop.
    pc0 = pulse_cnt;
    send_rbg(5, 0, ONE, ONE, 1'b0, 1'b0, 1'b0, 8'h60, 1'b0);
    send_rbg(12, 0, ONE, ONE, 1'b0, 1'b1, 1'b1, 8'h61, 1'b1);
    expect_close("sop_restart", pc0, 40'd24, 12, 1'b0, 1'b0, 8'h61, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
